// File: rtl/nb_remote_load_tracker.sv
// rtl/nb_remote_load_tracker.sv - per-register tracker of outstanding non-blocking remote loads
// Records issue PC and age per destination register and flags double issue, orphan responses and timeouts.
module nb_remote_load_tracker #(
   parameter int reg_els_p        = 32,
   parameter int reg_addr_width_p = 5,
   parameter int pc_width_p       = 32,
   parameter int timeout_p        = 4096,
   parameter int age_width_p      = 16,
   parameter int x_cord_width_p   = 4,
   parameter int y_cord_width_p   = 4,
   parameter bit messages_p       = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          issue_v_i,
   input  logic [reg_addr_width_p-1:0]   issue_rd_i,
   input  logic [pc_width_p-1:0]         issue_pc_i,
   input  logic                          resp_v_i,
   input  logic [reg_addr_width_p-1:0]   resp_rd_i,
   input  logic [reg_addr_width_p-1:0]   query_rd_i,
   output logic                          query_pending_o,
   output logic [pc_width_p-1:0]         query_pc_o,
   output logic [reg_els_p-1:0]          pending_o,
   output logic [reg_addr_width_p:0]     pending_count_o,
   output logic                          double_issue_o,
   output logic                          orphan_resp_o,
   output logic                          timeout_o,
   output logic [reg_addr_width_p-1:0]   err_rd_o,
   input  logic [x_cord_width_p-1:0]     my_x_i,
   input  logic [y_cord_width_p-1:0]     my_y_i
);

   logic [reg_els_p-1:0]        pending_q;
   logic [reg_els_p-1:0]        timed_out_q;
   logic [pc_width_p-1:0]       pc_q  [reg_els_p];
   logic [age_width_p-1:0]      age_q [reg_els_p];

   logic [reg_els_p-1:0]        iss, rsp, dbl, orph, to_hit, pend_nxt;
   logic [reg_addr_width_p:0]   cnt_nxt;
   logic [reg_addr_width_p-1:0] to_rd;
   logic                        to_any;

   always_comb begin
      iss      = '0;
      rsp      = '0;
      dbl      = '0;
      orph     = '0;
      to_hit   = '0;
      pend_nxt = '0;
      cnt_nxt  = '0;
      to_rd    = '0;
      to_any   = 1'b0;
      // Register 0 is hardwired: its entry is never touched.
      for (int r = 1; r < reg_els_p; r++) begin
         iss[r]      = issue_v_i && (issue_rd_i == reg_addr_width_p'(r));
         rsp[r]      = resp_v_i && (resp_rd_i == reg_addr_width_p'(r));
         dbl[r]      = iss[r] && pending_q[r] && !rsp[r];
         orph[r]     = rsp[r] && !pending_q[r];
         to_hit[r]   = pending_q[r] && !timed_out_q[r] && !iss[r] && !rsp[r] &&
                       (age_q[r] == age_width_p'(timeout_p - 1));
         pend_nxt[r] = iss[r] || (pending_q[r] && !rsp[r]);
      end
      // Descending scan so the lowest timed-out register is reported.
      for (int r = reg_els_p - 1; r >= 1; r--) begin
         if (to_hit[r]) begin
            to_any = 1'b1;
            to_rd  = reg_addr_width_p'(r);
         end
      end
      for (int r = 0; r < reg_els_p; r++) begin
         cnt_nxt = cnt_nxt + (reg_addr_width_p + 1)'(pend_nxt[r]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pending_q       <= '0;
         timed_out_q     <= '0;
         pending_count_o <= '0;
         double_issue_o  <= 1'b0;
         orphan_resp_o   <= 1'b0;
         timeout_o       <= 1'b0;
         err_rd_o        <= '0;
         for (int r = 0; r < reg_els_p; r++) begin
            pc_q[r]  <= '0;
            age_q[r] <= '0;
         end
      end else begin
         pending_q       <= pend_nxt;
         pending_count_o <= cnt_nxt;
         for (int r = 1; r < reg_els_p; r++) begin
            if (iss[r]) begin
               pc_q[r]        <= issue_pc_i;
               age_q[r]       <= '0;
               timed_out_q[r] <= 1'b0;
            end else if (rsp[r]) begin
               age_q[r]       <= '0;
               timed_out_q[r] <= 1'b0;
            end else if (pending_q[r]) begin
               if (age_q[r] != age_width_p'(timeout_p))
                  age_q[r] <= age_q[r] + 1'b1;
               if (to_hit[r])
                  timed_out_q[r] <= 1'b1;
            end
         end
         double_issue_o <= |dbl;
         orphan_resp_o  <= |orph;
         timeout_o      <= to_any;
         if (|dbl)
            err_rd_o <= issue_rd_i;
         else if (|orph)
            err_rd_o <= resp_rd_i;
         else if (to_any)
            err_rd_o <= to_rd;
      end
   end

   assign pending_o       = pending_q;
   assign query_pending_o = pending_q[query_rd_i];
   assign query_pc_o      = pc_q[query_rd_i];

   if (messages_p) begin : g_msg
      always @(negedge clk_i) begin
         if (!reset_i && (double_issue_o || orphan_resp_o || timeout_o))
            $error("t=%0t x=%0d y=%0d rd=%0d pc=%h dbl=%0b orphan=%0b timeout=%0b",
                   $time, my_x_i, my_y_i, err_rd_o, pc_q[err_rd_o],
                   double_issue_o, orphan_resp_o, timeout_o);
      end
   end

endmodule
